pio_in_debounce_irq: RTL



---
 rtl/pio_in_debounce_irq.sv | 92 +++++++++
 1 files changed

// File: rtl/pio_in_debounce_irq.sv
// pio_in_debounce_irq: debounced input PIO with per-bit edge capture and level IRQ on Avalon-MM
module pio_in_debounce_irq #(
  parameter int WIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] DEB_RST = '0,
  parameter logic [WIDTH-1:0] RISE_RST = '1,
  parameter logic [WIDTH-1:0] FALL_RST = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] s, q, q_d, irq_mask, edge_capture, rise_en, fall_en, ev, clr;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [31:0] rd_mux;
  logic wr, thresh_wr, unused_wd;
  assign wr = chipselect & ~write_n;
  assign thresh_wr = wr && address == 3'd6;
  assign s = sync[SYNC_STAGES-1];
  assign ev = (q & ~q_d & rise_en) | (~q & q_d & fall_en);
  assign clr = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
  assign irq = |(edge_capture & irq_mask);
  assign unused_wd = ^writedata;
  // bring the asynchronous pins into the clock domain
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
    end else begin
      sync[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  // per-channel debounce: q follows s only after thresh+1 consecutive mismatching cycles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (thresh_wr || s[i] == q[i]) cnt[i] <= '0;
        else if (cnt[i] == thresh) begin
          q[i] <= s[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // edge capture; a new event wins over a same-cycle W1C so nothing is lost
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q_d <= '0;
      edge_capture <= '0;
    end else begin
      q_d <= q;
      edge_capture <= (edge_capture & ~clr) | ev;
    end
  // software-writable control registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      irq_mask <= '0;
      rise_en <= RISE_RST;
      fall_en <= FALL_RST;
      thresh <= DEB_RST;
    end else if (wr) begin
      case (address)
        3'd2: irq_mask <= writedata[WIDTH-1:0];
        3'd4: rise_en <= writedata[WIDTH-1:0];
        3'd5: fall_en <= writedata[WIDTH-1:0];
        3'd6: thresh <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  // read mux, zero-extended to the bus width
  always_comb
    rd_mux = address == 3'd0 ? 32'(q) :
             address == 3'd1 ? 32'(s) :
             address == 3'd2 ? 32'(irq_mask) :
             address == 3'd3 ? 32'(edge_capture) :
             address == 3'd4 ? 32'(rise_en) :
             address == 3'd5 ? 32'(fall_en) :
             address == 3'd6 ? 32'(thresh) : 32'd0;
  // registered read data, one cycle latency, independent of chipselect
  always_ff @(posedge clk or posedge reset)
    if (reset) readdata <= '0;
    else readdata <= rd_mux;
endmodule
